// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issues one operation at a time to a combinational 16-bit ALU, holds the operands
// for a per-op window, then returns a registered result with regenerated flags. Option: OVERFLOW_DETECT_EN.
module alu_op_sequencer #(
    parameter int unsigned MUL_LAT = 2,
    parameter int unsigned DIV_LAT = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [2:0]  alu_sel,
    input  logic [15:0] alu_out,
    input  logic        alu_zero,
    input  logic        alu_less,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic        rsp_zero,
    output logic        rsp_less,
    output logic        rsp_err,
    output logic        rsp_ovf
);

    localparam logic [2:0] SEL_ADD = 3'b000;
    localparam logic [2:0] SEL_SUB = 3'b001;
    localparam logic [2:0] SEL_MUL = 3'b010;
    localparam logic [2:0] SEL_DIV = 3'b011;

    localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);
    localparam logic [3:0] DIV_CNT = 4'(DIV_LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] alu_a_q, alu_a_d;
    logic [15:0] alu_b_q, alu_b_d;
    logic [2:0]  alu_sel_q, alu_sel_d;
    logic [15:0] rsp_result_q, rsp_result_d;
    logic        rsp_zero_q, rsp_zero_d;
    logic        rsp_less_q, rsp_less_d;
    logic        rsp_err_q, rsp_err_d;
    logic        illegal_accept;
    logic        capture;
    logic        div_by_zero;
    logic [15:0] result_sel;

    // The ALU's own flags are not trusted; they are regenerated from the held operands.
    logic unused_alu_flags;
    assign unused_alu_flags = alu_zero ^ alu_less;

    function automatic logic [3:0] lat_cnt(input logic [2:0] sel);
        case (sel)
            SEL_MUL: lat_cnt = MUL_CNT;
            SEL_DIV: lat_cnt = DIV_CNT;
            default: lat_cnt = 4'd0;
        endcase
    endfunction

    function automatic logic calc_less(input logic [2:0]  sel,
                                       input logic [15:0] a,
                                       input logic [15:0] b,
                                       input logic [15:0] res);
        logic signed [15:0] sa;
        logic signed [15:0] sb;
        sa = $signed(a);
        sb = $signed(b);
        case (sel)
            SEL_SUB: calc_less = (sa < sb);
            SEL_ADD: calc_less = res[15];
            default: calc_less = 1'b0;
        endcase
    endfunction

    assign illegal_accept = (state_q == IDLE) && req_valid && req_op[3];
    assign capture        = (state_q == EXEC) && (cnt_q == 4'd0);
    assign div_by_zero    = (alu_sel_q == SEL_DIV) && (alu_b_q == 16'd0);
    assign result_sel     = div_by_zero ? 16'hFFFF : alu_out;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_sel_d    = alu_sel_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_less_d   = rsp_less_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_op[3]) begin
                        rsp_result_d = 16'd0;
                        rsp_zero_d   = 1'b0;
                        rsp_less_d   = 1'b0;
                        rsp_err_d    = 1'b1;
                        state_d      = RESP;
                    end else begin
                        alu_a_d   = req_a;
                        alu_b_d   = req_b;
                        alu_sel_d = req_op[2:0];
                        cnt_d     = lat_cnt(req_op[2:0]);
                        state_d   = EXEC;
                    end
                end
            end
            EXEC: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rsp_result_d = result_sel;
                    rsp_zero_d   = (result_sel == 16'd0);
                    rsp_less_d   = calc_less(alu_sel_q, alu_a_q, alu_b_q, alu_out);
                    rsp_err_d    = div_by_zero;
                    state_d      = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            alu_a_q      <= 16'd0;
            alu_b_q      <= 16'd0;
            alu_sel_q    <= 3'd0;
            rsp_result_q <= 16'd0;
            rsp_zero_q   <= 1'b0;
            rsp_less_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_sel_q    <= alu_sel_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_less_q   <= rsp_less_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

`ifdef OVERFLOW_DETECT_EN
    logic rsp_ovf_q, rsp_ovf_d;

    function automatic logic calc_ovf(input logic [2:0]  sel,
                                      input logic [15:0] a,
                                      input logic [15:0] b,
                                      input logic [15:0] res);
        logic [31:0] prod;
        prod = {16'd0, a} * {16'd0, b};
        case (sel)
            SEL_ADD: calc_ovf = (a[15] == b[15]) && (res[15] != a[15]);
            SEL_SUB: calc_ovf = (a[15] != b[15]) && (res[15] != a[15]);
            SEL_MUL: calc_ovf = |prod[31:16];
            default: calc_ovf = 1'b0;
        endcase
    endfunction

    always_comb begin
        rsp_ovf_d = rsp_ovf_q;
        if (illegal_accept) begin
            rsp_ovf_d = 1'b0;
        end else if (capture) begin
            rsp_ovf_d = calc_ovf(alu_sel_q, alu_a_q, alu_b_q, alu_out);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_ovf_q <= 1'b0;
        end else begin
            rsp_ovf_q <= rsp_ovf_d;
        end
    end

    assign rsp_ovf = rsp_ovf_q;
`else
    logic unused_ovf_ctl;
    assign unused_ovf_ctl = illegal_accept ^ capture;
    assign rsp_ovf        = 1'b0;
`endif

    assign req_ready  = (state_q == IDLE);
    assign rsp_valid  = (state_q == RESP);
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_sel    = alu_sel_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_less   = rsp_less_q;
    assign rsp_err    = rsp_err_q;

endmodule
